// File: rtl/change_dispenser_if.sv
// Handshake and hopper signals between the vend controller / hoppers and the change dispenser.
// master is the environment side, slave is the dispenser.
interface change_dispenser_if #(
    parameter int unsigned CREDIT_W = 8
) ();
    logic                start;
    logic [CREDIT_W-1:0] amount;
    logic                empty5;
    logic                empty2;
    logic                empty1;
    logic                coin_sense;
    logic                busy;
    logic                eject5;
    logic                eject2;
    logic                eject1;
    logic                done;
    logic [CREDIT_W-1:0] shortfall;
    logic                err;

    modport master (
        output start, amount, empty5, empty2, empty1, coin_sense,
        input  busy, eject5, eject2, eject1, done, shortfall, err
    );

    modport slave (
        input  start, amount, empty5, empty2, empty1, coin_sense,
        output busy, eject5, eject2, eject1, done, shortfall, err
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy $5/$2/$1 coin payout sequencer: one eject pulse per coin, confirmed by the drop sensor,
// skipping empty or unresponsive hoppers and reporting the undispensed shortfall.
module change_dispenser #(
    parameter int unsigned CREDIT_W     = 8,
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 4,
    parameter int unsigned ACK_TIMEOUT  = 255
) (
    input logic              clk,
    input logic              rst,
    change_dispenser_if.slave bus
);
    localparam int unsigned MaxPg  = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned CntMax = (MaxPg > ACK_TIMEOUT) ? MaxPg : ACK_TIMEOUT;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [2:0] {StIdle, StSelect, StEject, StWaitSense, StGap, StDone} state_e;

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] rem_q, rem_d;
    logic [2:0]          den_q, den_d;     // one-hot {5, 2, 1}
    logic [2:0]          fault_q, fault_d; // one-hot {f5, f2, f1}
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                sensed_q, sensed_d;
    logic                busy_q, done_q, err_q;
    logic [2:0]          eject_q;
    logic [CREDIT_W-1:0] shortfall_q;
    logic                busy_d, done_d, err_d;
    logic [2:0]          eject_d;
    logic [CREDIT_W-1:0] shortfall_d;
    logic [CREDIT_W-1:0] den_val;
    logic [2:0]          elig;

    always_comb begin
        den_val = '0;
        if (den_q[2]) begin
            den_val = CREDIT_W'(5);
        end else if (den_q[1]) begin
            den_val = CREDIT_W'(2);
        end else if (den_q[0]) begin
            den_val = CREDIT_W'(1);
        end
    end

    assign elig[2] = (rem_q >= CREDIT_W'(5)) && !bus.empty5 && !fault_q[2];
    assign elig[1] = (rem_q >= CREDIT_W'(2)) && !bus.empty2 && !fault_q[1];
    assign elig[0] = (rem_q >= CREDIT_W'(1)) && !bus.empty1 && !fault_q[0];

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        den_d    = den_q;
        fault_d  = fault_q;
        cnt_d    = cnt_q;
        sensed_d = sensed_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    rem_d   = bus.amount;
                    fault_d = '0;
                    state_d = StSelect;
                end
            end
            StSelect: begin
                cnt_d    = '0;
                sensed_d = 1'b0;
                state_d  = StEject;
                if (elig[2]) begin
                    den_d = 3'b100;
                end else if (elig[1]) begin
                    den_d = 3'b010;
                end else if (elig[0]) begin
                    den_d = 3'b001;
                end else begin
                    state_d = StDone;
                end
            end
            StEject: begin
                if (bus.coin_sense) begin
                    sensed_d = 1'b1;
                end
                if (cnt_q == CntW'(PULSE_CYCLES - 1)) begin
                    cnt_d = '0;
                    // A sense in the final pulse cycle counts as seen during the pulse.
                    if (sensed_q || bus.coin_sense) begin
                        rem_d   = rem_q - den_val;
                        state_d = StGap;
                    end else begin
                        state_d = StWaitSense;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitSense: begin
                if (bus.coin_sense) begin
                    rem_d   = rem_q - den_val;
                    cnt_d   = '0;
                    state_d = StGap;
                end else if (cnt_q == CntW'(ACK_TIMEOUT - 1)) begin
                    fault_d = fault_q | den_q;
                    cnt_d   = '0;
                    state_d = StGap;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (cnt_q == CntW'(GAP_CYCLES - 1)) begin
                    state_d = StSelect;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered and aligned with the state.
    always_comb begin
        busy_d      = (state_d != StIdle);
        eject_d     = (state_d == StEject) ? den_d : 3'b000;
        done_d      = (state_d == StDone);
        err_d       = done_d && (rem_d != '0);
        shortfall_d = done_d ? rem_d : shortfall_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            rem_q       <= '0;
            den_q       <= '0;
            fault_q     <= '0;
            cnt_q       <= '0;
            sensed_q    <= 1'b0;
            busy_q      <= 1'b0;
            eject_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            shortfall_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            den_q       <= den_d;
            fault_q     <= fault_d;
            cnt_q       <= cnt_d;
            sensed_q    <= sensed_d;
            busy_q      <= busy_d;
            eject_q     <= eject_d;
            done_q      <= done_d;
            err_q       <= err_d;
            shortfall_q <= shortfall_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.eject5    = eject_q[2];
    assign bus.eject2    = eject_q[1];
    assign bus.eject1    = eject_q[0];
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.shortfall = shortfall_q;
endmodule

// File: doc/change_dispenser.md
# change_dispenser

Sequencing controller for the coin-return hoppers. It takes the change amount the vend controller computes after a purchase and pays it out greedily in $5, $2 and $1 coins. Each coin is one eject pulse to a hopper, confirmed by the shared drop sensor before the next coin is released. The block skips hoppers that are empty or unresponsive and reports any undispensed shortfall back to the controller.

## Interface
- CREDIT_W, 8, width of amount and shortfall (dollars)
- PULSE_CYCLES, 4, eject pulse width in cycles (≥1)
- GAP_CYCLES, 4, minimum eject-low cycles between consecutive coins (≥1)
- ACK_TIMEOUT, 255, cycles waited in WAIT_SENSE for coin_sense before faulting a hopper (≥1)

- clk  in  1  system clock, all logic on posedge
- rst  in  1  reset, asynchronous, active-low; 0 clears all state and outputs immediately
- start  in  1  one-cycle request; amount sampled on the same edge
- amount  in  CREDIT_W  change to dispense
- empty5 / empty2 / empty1  in  1 each  hopper empty level, 1 = no coins
- coin_sense  in  1  drop-sensor pulse; one pulse per coin
- busy  out  1  high from the cycle after an accepted start until done
- eject5 / eject2 / eject1  out  1 each  hopper eject drive; at most one high at any time
- done  out  1  one-cycle completion pulse
- shortfall  out  CREDIT_W  undispensed remainder; valid while done=1, holds its value until the next done
- err  out  1  one-cycle pulse coincident with done when shortfall≠0

## Operation
- States: IDLE, SELECT, EJECT, WAIT_SENSE, GAP, DONE.
- Internal state: remaining (CREDIT_W), selected denomination d, cycle counter, and fault flags f5/f2/f1. Fault flags are cleared on every accepted start.
- IDLE:
  - start=1 → latch remaining=amount, clear faults, go to SELECT.
  - start with amount=0 still goes through SELECT, which goes straight to DONE with no ejects.
- SELECT (1 cycle):
  - d = largest of 5, 2, 1 with remaining≥d, empty_d=0 and f_d=0.
  - remaining=0 or no eligible d → DONE.
  - Otherwise → EJECT.
  - Empty and fault inputs are evaluated only here. A change of empty_d during an eject is ignored until the next SELECT.
- EJECT: eject_d high for exactly PULSE_CYCLES cycles.
  - A coin_sense seen during EJECT is latched.
  - At pulse end, latched sense → GAP; otherwise → WAIT_SENSE.
- WAIT_SENSE:
  - coin_sense → remaining -= d, go to GAP.
  - ACK_TIMEOUT cycles without sense → set f_d, leave remaining unchanged, go to GAP.
- Sense latched during EJECT also performs remaining -= d on the transition to GAP.
- GAP: all ejects low for GAP_CYCLES cycles → SELECT.
- DONE (1 cycle): done=1, shortfall=remaining, err=(remaining≠0) → IDLE.
- coin_sense outside EJECT/WAIT_SENSE is ignored; no decrement.
- More than one sense per coin: only the first counts.
- Subtraction never underflows, since d≤remaining is guaranteed in SELECT.

## Timing
- Reset values: busy=0, eject5/2/1=0, done=0, err=0, shortfall=0, state IDLE, faults cleared.
- start at edge N → busy=1 and SELECT during cycle N+1; eject_d rises at N+2 if a coin is eligible.
- Per coin with sense during the pulse: 1 + PULSE_CYCLES + GAP_CYCLES cycles.
- Sense k cycles after the pulse ends: add k+1 cycles.
- No eligible coin at the first SELECT: done at cycle N+2, busy falls at N+3.
- busy drops the cycle after done.
- start while busy=1 is ignored.
- start on the same edge as done is ignored. The requester must wait for busy=0.
- rst low mid-EJECT: eject drops asynchronously, no done pulse, and remaining is lost.
- Outputs are registered; no combinational path from inputs to ejects.

## Test plan
- amount=8, all hoppers full, sense 2 cycles after each pulse end → eject5, eject2, eject1 once each in that order. Then done with shortfall=0, err=0. Check ejects are never simultaneous and each gap is ≥GAP_CYCLES.
- amount=4, empty2=1 → four eject1 pulses, no eject2; done, shortfall=0.
- amount=7, all empty → no eject; done 2 cycles after start with shortfall=7, err=1.
- amount=5, hopper5 never senses (others sense normally) → eject5 once, then ACK_TIMEOUT expiry. f5 set, then eject2, eject2, eject1; done with shortfall=0. A following start with amount=5 clears f5 and attempts eject5 again.
- amount=0 → done with shortfall=0 and no ejects. A second start issued while busy (amount=3 run) is ignored, and exactly one done occurs.
- amount=5, rst low during the 2nd cycle of eject5 → eject5, busy, done and err all 0 immediately. After release, an amount=2 start dispenses a single $2 normally.
